// File: rtl/axi_hdr_insert_pkg.sv
// axi_hdr_insert_pkg: shared FSM states and header keep legality for the header-insert scheduler
package axi_hdr_insert_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;
  function automatic logic keep_legal(input logic [7:0] k);
    return (k != 8'd0) && ((k & (k + 8'd1)) == 8'd0);
  endfunction
endpackage

// File: rtl/axi_hdr_insert_sched_rr_pick.sv
// rr_pick: first set request at or after ptr, with wrap-around
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_WD = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_WD-1:0]   ptr,
  output logic               any,
  output logic [ID_WD-1:0]   idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) idx = ID_WD'((int'(ptr) + i) % NUM_REQ);
  end
endmodule

// File: rtl/axi_hdr_insert_sched.sv
// axi_hdr_insert_sched: round-robin packet scheduler feeding one header-insert block
module axi_hdr_insert_sched
  import axi_hdr_insert_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = 3,
  parameter int NUM_REQ = 4,
  parameter int ID_WD = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              s_valid_insert,
  input  logic [NUM_REQ*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_REQ-1:0]              s_ready_insert,
  input  logic [NUM_REQ-1:0]              s_valid_in,
  input  logic [NUM_REQ*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_REQ-1:0]              s_last_in,
  output logic [NUM_REQ-1:0]              s_ready_in,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,
  output logic                            grant_vld,
  output logic [ID_WD-1:0]                grant_id,
  output logic                            pkt_done,
  output logic                            hdr_err
);
  state_t state, state_nx;
  logic [ID_WD-1:0] rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] sel;
  logic pick_any, hdr_act, pld_act, hdr_hs, pld_last_hs, hdr_bad;
  rr_pick #(.NUM_REQ(NUM_REQ), .ID_WD(ID_WD)) u_rr_pick (
    .req(s_valid_insert),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
  // reset gates every handshake combinationally, even before the first edge
  assign hdr_act = !rst && state == HDR;
  assign pld_act = !rst && state == PLD;
  assign grant_vld = !rst && state != IDLE;
  assign sel = NUM_REQ'(1) << grant_id;
  assign valid_insert = hdr_act && s_valid_insert[grant_id];
  assign data_insert = hdr_act ? s_data_insert[grant_id*DATA_WD +: DATA_WD] : '0;
  assign keep_insert = hdr_act ? s_keep_insert[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign byte_insert_cnt = hdr_act ? s_byte_insert_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD] : '0;
  assign s_ready_insert = {NUM_REQ{hdr_act && ready_insert}} & sel;
  assign valid_in = pld_act && s_valid_in[grant_id];
  assign data_in = pld_act ? s_data_in[grant_id*DATA_WD +: DATA_WD] : '0;
  assign keep_in = pld_act ? s_keep_in[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign last_in = pld_act && s_last_in[grant_id];
  assign s_ready_in = {NUM_REQ{pld_act && ready_in}} & sel;
  assign hdr_hs = valid_insert && ready_insert;
  assign pld_last_hs = valid_in && ready_in && last_in;
  assign hdr_bad = !keep_legal(8'(keep_insert)) ||
                   byte_insert_cnt != BYTE_CNT_WD'($countones(keep_insert));
  always_comb begin
    state_nx = (state == IDLE && pick_any) ? HDR :
               hdr_hs      ? PLD  :
               pld_last_hs ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      pkt_done <= 1'b0;
      hdr_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) grant_id <= pick_idx;
      if (pld_last_hs) rr_ptr <= (grant_id == ID_WD'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      pkt_done <= pld_last_hs;
      hdr_err <= hdr_hs && hdr_bad;
    end
  end
endmodule

// File: tb/tb_axi_hdr_insert_sched.sv
// tb_axi_hdr_insert_sched: table-driven, directed and randomized checks against a packet-level model
module tb_axi_hdr_insert_sched;
  localparam int N = 4, DW = 32, KW = 4, CW = 3;
  logic clk = 1'b0, rst;
  logic [N-1:0] s_valid_insert, s_ready_insert, s_valid_in, s_last_in, s_ready_in;
  logic [N*DW-1:0] s_data_insert, s_data_in;
  logic [N*KW-1:0] s_keep_insert, s_keep_in;
  logic [N*CW-1:0] s_byte_insert_cnt;
  logic valid_insert, ready_insert, valid_in, ready_in, last_in, grant_vld, pkt_done, hdr_err;
  logic [DW-1:0] data_insert, data_in;
  logic [KW-1:0] keep_insert, keep_in;
  logic [CW-1:0] byte_insert_cnt;
  logic [1:0] grant_id;

  axi_hdr_insert_sched dut (
    .clk(clk), .rst(rst),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert), .s_keep_insert(s_keep_insert),
    .s_byte_insert_cnt(s_byte_insert_cnt), .s_ready_insert(s_ready_insert),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .grant_vld(grant_vld), .grant_id(grant_id),
    .pkt_done(pkt_done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic [2:0] c;} hdr_t;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  typedef struct {logic [3:0] k; logic [2:0] c; int e;} vec_t;

  hdr_t hq[N][$], mh[N][$];
  beat_t bq[N][$], mb[N][$];
  int n_chk, n_fail, pd_cnt, err_cnt, beats, cyc, last_cyc, m_ptr, m_src;
  bit exp_pd, exp_err;
  int gorder[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // a header is malformed when its keep is not one of the LSB-aligned masks or disagrees with its count
  function automatic bit bad(input hdr_t h);
    bit legal;
    legal = h.k inside {4'b0001, 4'b0011, 4'b0111, 4'b1111};
    return !legal || ($countones(h.k) != int'(h.c));
  endfunction

  function automatic bit all_empty();
    for (int s = 0; s < N; s++) if (mh[s].size() != 0 || mb[s].size() != 0) return 0;
    return 1;
  endfunction

  task automatic add_pkt(input int s, input hdr_t h, input int nb, input logic [3:0] lk);
    beat_t b;
    hq[s].push_back(h);
    mh[s].push_back(h);
    for (int i = 0; i < nb; i++) begin
      b.d = $urandom;
      b.k = (i == nb - 1) ? lk : 4'hf;
      b.l = (i == nb - 1);
      bq[s].push_back(b);
      mb[s].push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int s = 0; s < N; s++) begin
      hq[s].delete(); bq[s].delete(); mh[s].delete(); mb[s].delete();
    end
    m_src = -1; m_ptr = 0; exp_pd = 0; exp_err = 0; last_cyc = -10;
  endtask

  task automatic step(input int duty);
    int nxt;
    hdr_t h;
    beat_t b;
    @(negedge clk);
    cyc++;
    chk("pkt_done", pkt_done, exp_pd);
    chk("hdr_err", hdr_err, exp_err);
    pd_cnt += int'(pkt_done);
    err_cnt += int'(hdr_err);
    exp_pd = 0; exp_err = 0;
    for (int s = 0; s < N; s++) begin
      h = (hq[s].size() != 0) ? hq[s][0] : '0;
      s_valid_insert[s] = hq[s].size() != 0;
      s_data_insert[s*DW +: DW] = h.d;
      s_keep_insert[s*KW +: KW] = h.k;
      s_byte_insert_cnt[s*CW +: CW] = h.c;
      b = (bq[s].size() != 0) ? bq[s][0] : '0;
      s_valid_in[s] = bq[s].size() != 0 && $urandom_range(99) < duty;
      s_data_in[s*DW +: DW] = b.d;
      s_keep_in[s*KW +: KW] = b.k;
      s_last_in[s] = b.l;
    end
    ready_insert = $urandom_range(99) < duty;
    ready_in = $urandom_range(99) < duty;
    #1;
    chk("rdy_mask", (s_ready_in | s_ready_insert) & ~(4'b1 << grant_id), 0);
    if (valid_insert && ready_insert) begin
      nxt = -1;
      for (int i = N - 1; i >= 0; i--) if (mh[(m_ptr + i) % N].size() != 0) nxt = (m_ptr + i) % N;
      chk("hdr_while_busy", m_src < 0, 1);
      chk("bubble", cyc - last_cyc >= 2, 1);
      chk("hdr_pending", nxt >= 0, 1);
      if (nxt >= 0) begin
        chk("hdr_grant", grant_id, nxt);
        gorder.push_back(int'(grant_id));
        h = mh[nxt].pop_front();
        chk("hdr_data", data_insert, h.d);
        chk("hdr_keep", keep_insert, h.k);
        chk("hdr_cnt", byte_insert_cnt, h.c);
        exp_err = bad(h);
        m_src = nxt;
      end
    end
    if (valid_in && ready_in) begin
      chk("pld_granted", m_src >= 0 && mb[m_src < 0 ? 0 : m_src].size() != 0, 1);
      if (m_src >= 0 && mb[m_src].size() != 0) begin
        chk("pld_grant", grant_id, m_src);
        b = mb[m_src].pop_front();
        chk("pld_data", data_in, b.d);
        chk("pld_keep", keep_in, b.k);
        chk("pld_last", last_in, b.l);
        beats++;
        if (b.l) begin
          exp_pd = 1; m_ptr = (m_src + 1) % N; m_src = -1; last_cyc = cyc;
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      if (s_valid_insert[s] && s_ready_insert[s]) hq[s].delete(0);
      if (s_valid_in[s] && s_ready_in[s]) bq[s].delete(0);
    end
  endtask

  task automatic run(input int duty, input int stop_beats);
    int t = 0;
    while (t < 3000 && !(stop_beats > 0 ? beats >= stop_beats : (m_src < 0 && all_empty()))) begin
      step(duty);
      t++;
    end
    chk("run_done", t < 3000, 1);
    if (stop_beats == 0) repeat (2) step(duty);
  endtask

  vec_t tbl[7];
  int exp_ord[5];
  int pd0, e0, b0, tot, s;

  initial begin
    tbl[0] = '{4'b0111, 3'd3, 0};
    tbl[1] = '{4'b0101, 3'd2, 1};
    tbl[2] = '{4'b1111, 3'd3, 1};
    tbl[3] = '{4'b0001, 3'd1, 0};
    tbl[4] = '{4'b1111, 3'd4, 0};
    tbl[5] = '{4'b0011, 3'd1, 1};
    tbl[6] = '{4'b0000, 3'd0, 1};
    exp_ord = '{0, 1, 2, 3, 1};
    n_chk = 0; n_fail = 0; pd_cnt = 0; err_cnt = 0; beats = 0; cyc = 0;
    rst = 1'b1;
    s_valid_insert = '1; s_valid_in = '1; s_last_in = '0;
    s_data_insert = '0; s_keep_insert = '0; s_byte_insert_cnt = '0;
    s_data_in = '0; s_keep_in = '0;
    ready_insert = 1'b1; ready_in = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_valid_insert", valid_insert, 0);
    chk("rst_valid_in", valid_in, 0);
    chk("rst_ready", {s_ready_insert, s_ready_in}, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_hdr_err", hdr_err, 0);
    s_valid_insert = '0; s_valid_in = '0;
    rst = 1'b0;

    // all four sources at once, src1 queues a second packet
    for (int i = 0; i < N; i++) add_pkt(i, {32'($urandom), 4'b1111, 3'd4}, 2, 4'hf);
    add_pkt(1, {32'($urandom), 4'b0011, 3'd2}, 1, 4'h1);
    gorder.delete();
    run(100, 0);
    chk("order_len", gorder.size(), 5);
    for (int i = 0; i < 5 && i < gorder.size(); i++) chk($sformatf("grant_order%0d", i), gorder[i], exp_ord[i]);

    // single source, 3 beats
    pd0 = pd_cnt; e0 = err_cnt;
    add_pkt(0, {32'hAABBCCDD, 4'b0111, 3'd3}, 3, 4'b1100);
    run(100, 0);
    chk("single_pkt_done", pd_cnt - pd0, 1);
    chk("single_hdr_err", err_cnt - e0, 0);

    // header check vectors
    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt;
      add_pkt(i % N, {32'($urandom), tbl[i].k, tbl[i].c}, 1 + i % 3, 4'hf);
      run(100, 0);
      chk($sformatf("hdr_err_vec%0d", i), err_cnt - e0, tbl[i].e);
    end

    // random sources, lengths and backpressure
    pd0 = pd_cnt; b0 = beats; tot = 0;
    for (int i = 0; i < 5; i++) begin
      s = $urandom_range(N - 1);
      e0 = $urandom_range(1, 5);
      tot += e0;
      add_pkt(s, {32'($urandom), 4'($urandom), 3'($urandom)}, e0, 4'($urandom));
    end
    run(80, 0);
    chk("rand_pkt_done", pd_cnt - pd0, 5);
    chk("rand_beats", beats - b0, tot);

    // payload offered before its header is accepted
    @(negedge clk);
    s_valid_insert = 4'b0001; s_data_insert = '0; s_data_insert[31:0] = 32'h11223344;
    s_keep_insert = '0; s_keep_insert[3:0] = 4'hf;
    s_byte_insert_cnt = '0; s_byte_insert_cnt[2:0] = 3'd4;
    s_valid_in = 4'b0001; s_data_in = '0; s_data_in[31:0] = 32'h55667788;
    s_keep_in = '0; s_keep_in[3:0] = 4'h3; s_last_in = 4'b0001;
    ready_insert = 1'b0; ready_in = 1'b1;
    #1;
    chk("arb_lat0", valid_insert, 0);
    chk("early_pld_rdy0", s_ready_in, 0);
    @(negedge clk); #1;
    chk("arb_lat1", valid_insert, 1);
    chk("early_grant", grant_id, 0);
    chk("early_pld_rdy1", s_ready_in, 0);
    chk("early_valid_in", valid_in, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("early_pld_hold", s_ready_in, 0);
    end
    @(negedge clk);
    ready_insert = 1'b1;
    #1;
    chk("early_hdr_rdy", s_ready_insert, 4'b0001);
    @(negedge clk);
    ready_insert = 1'b0; s_valid_insert = '0;
    #1;
    chk("early_pld_open", s_ready_in, 4'b0001);
    chk("early_ins_closed", s_ready_insert, 0);
    chk("early_pld_data", data_in, 32'h55667788);
    @(negedge clk);
    s_valid_in = '0;
    #1;
    chk("early_pkt_done", pkt_done, 1);
    chk("early_idle", grant_vld, 0);
    m_ptr = 1;

    // reset after 2 of 4 beats
    beats = 0;
    add_pkt(0, {32'($urandom), 4'b0001, 3'd1}, 4, 4'hf);
    run(100, 2);
    @(negedge clk);
    rst = 1'b1; s_valid_insert = '1; s_valid_in = '1; ready_insert = 1'b1; ready_in = 1'b1;
    #1;
    chk("mid_rst_valid", {valid_insert, valid_in}, 0);
    chk("mid_rst_ready", {s_ready_insert, s_ready_in}, 0);
    chk("mid_rst_grant_vld", grant_vld, 0);
    @(negedge clk); #1;
    chk("mid_rst_pkt_done", pkt_done, 0);
    chk("mid_rst_grant_vld2", grant_vld, 0);
    rst = 1'b0; s_valid_insert = '0; s_valid_in = '0;
    clear_all();
    pd0 = pd_cnt;
    gorder.delete();
    add_pkt(3, {32'($urandom), 4'b0011, 3'd2}, 2, 4'hf);
    add_pkt(2, {32'($urandom), 4'b0111, 3'd3}, 3, 4'hf);
    run(100, 0);
    chk("post_rst_first", gorder.size() > 0 ? gorder[0] : -1, 2);
    chk("post_rst_pkts", pd_cnt - pd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
